// File: rtl/settings_pkg.sv
// Shared shaper settings: result width, channel count and per-channel FIFO depth.
package settings_pkg;

    localparam int FULL_SIZE         = 24;
    localparam int NUM_CHANNELS      = 4;
    localparam int RESULT_FIFO_DEPTH = 4;

    typedef logic signed [FULL_SIZE-1:0]          result_t;
    typedef logic [$clog2(NUM_CHANNELS)-1:0]      channel_id_t;

endpackage

// File: rtl/trapez_result_fifo.sv
// Small synchronous FIFO buffering one shaper's results; a push into a full
// FIFO is only accepted when a pop frees a slot in the same cycle.
module trapez_result_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trapez_shaper_result_mux.sv
// Merges per-channel shaper results round-robin into one channel-tagged
// ready/valid stream; shapers cannot stall, so overflows are dropped and flagged.
module trapez_shaper_result_mux
    import settings_pkg::FULL_SIZE;
    import settings_pkg::RESULT_FIFO_DEPTH;
#(
    parameter int NUM_CHANNELS = settings_pkg::NUM_CHANNELS,
    parameter int DATA_WIDTH   = FULL_SIZE,
    parameter int FIFO_DEPTH   = RESULT_FIFO_DEPTH,
    parameter int CH_ID_WIDTH  = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    output logic signed [DATA_WIDTH-1:0]       out_data,
    output logic [CH_ID_WIDTH-1:0]             out_channel,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_CHANNELS-1:0]            overflow,
    input  logic [NUM_CHANNELS-1:0]            clear_overflow
);

    logic [DATA_WIDTH-1:0]   fifo_head [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_pop;
    logic [NUM_CHANNELS-1:0] drop;
    logic [CH_ID_WIDTH-1:0]  rr_ptr;
    logic [CH_ID_WIDTH-1:0]  grant_ch;
    logic [CH_ID_WIDTH-1:0]  candidate;
    logic                    grant_found;
    logic                    load_en;

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_fifo
        trapez_result_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (in_valid[k]),
            .pop      (fifo_pop[k]),
            .push_data(in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .head_data(fifo_head[k]),
            .full     (fifo_full[k]),
            .empty    (fifo_empty[k])
        );
    end

    assign load_en = !out_valid || out_ready;
    assign drop    = in_valid & fifo_full & ~fifo_pop;

    // Search starts one past the last winner so every busy channel gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        candidate   = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            candidate = CH_ID_WIDTH'((int'(rr_ptr) + i) % NUM_CHANNELS);
            if (!grant_found && !fifo_empty[candidate]) begin
                grant_found = 1'b1;
                grant_ch    = candidate;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (load_en && grant_found) fifo_pop[grant_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data    <= '0;
            out_channel <= '0;
            out_valid   <= 1'b0;
            rr_ptr      <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
            overflow    <= '0;
        end else begin
            overflow <= (overflow & ~clear_overflow) | drop;
            if (load_en) begin
                if (grant_found) begin
                    out_data    <= fifo_head[grant_ch];
                    out_channel <= grant_ch;
                    out_valid   <= 1'b1;
                    rr_ptr      <= grant_ch;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
